// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared types and helpers for the multi-port register file
package reg_file_mp_pkg;
  localparam int XLEN_DEF = 32;
  typedef logic [XLEN_DEF-1:0] word_t;
  typedef enum logic {RF_IDLE, RF_CLEARING} rf_state_t;
  function automatic int rf_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: pending-write bits with set-over-clear priority and per-port lookup
module reg_file_scoreboard
  import reg_file_mp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic [1:0]        clr_en_i,
  input  logic [2*AW-1:0]   clr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  always_comb begin
    busy_d = busy_q;
    for (int j = 0; j < 2; j++)
      if (clr_en_i[j]) busy_d[clr_addr_i[j*AW +: AW]] = 1'b0;
    if (set_en_i && !(ZERO_REG != 0 && set_addr_i == '0)) busy_d[set_addr_i] = 1'b1;
    if (flush_i) busy_d = '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) busy_q <= '0;
    else busy_q <= busy_d;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_busy_o[i] = busy_q[rd_addr_i[i*AW +: AW]];
  end
endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised 2-write/NRD-read register file with bypass, scoreboard
// and a hardware clear sequencer that zeroes the array after reset or on request
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int ZERO_REG = 1,
  localparam int AW = rf_aw(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear_req,
  output logic                ready,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_addr,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                busy_set_en,
  input  logic [AW-1:0]       busy_set_addr
);
  rf_state_t       state_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic            idle;
  logic [1:0]      acc;
  logic [AW-1:0]   wa [2];
  logic [XLEN-1:0] wd [2];
  assign idle  = state_q == RF_IDLE;
  assign ready = idle;
  for (genvar j = 0; j < 2; j++) begin : g_wr
    assign wa[j]  = wr_addr[j*AW +: AW];
    assign wd[j]  = wr_data[j*XLEN +: XLEN];
    assign acc[j] = idle && wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RF_CLEARING;
      idx_q   <= '0;
    end else if (idle) begin
      if (clear_req) begin
        state_q <= RF_CLEARING;
        idx_q   <= '0;
      end
    end else begin
      idx_q <= idx_q + AW'(1);
      if (idx_q == AW'(NREGS - 1)) state_q <= RF_IDLE;
    end
  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk)
    if (!idle) regs_q[idx_q] <= '0;
    else begin
      if (acc[0]) regs_q[wa[0]] <= wd[0];
      if (acc[1]) regs_q[wa[1]] <= wd[1];
    end
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = rd_addr[i*AW +: AW];
    assign rd_data[i*XLEN +: XLEN] = (!idle || (ZERO_REG != 0 && ra == '0)) ? '0 :
                                     (acc[1] && wa[1] == ra) ? wd[1] :
                                     (acc[0] && wa[0] == ra) ? wd[0] : regs_q[ra];
  end
  reg_file_scoreboard #(.NREGS(NREGS), .NRD(NRD), .ZERO_REG(ZERO_REG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (!idle || clear_req),
    .set_en_i  (idle && busy_set_en),
    .set_addr_i(busy_set_addr),
    .clr_en_i  (acc),
    .clr_addr_i({wa[1], wa[0]}),
    .rd_addr_i (rd_addr),
    .rd_busy_o (rd_busy)
  );
endmodule
